// File: rtl/t_counter_n.sv
// t_counter_n: WIDTH-bit modulo-MOD counter built from per-bit toggle cells.
// Modes: up, down, per-bit toggle and load. It provides a combinational
// terminal-count lookahead for cascading, a registered wrap pulse and a
// sticky overflow/illegal-operation flag.
// Legal parameters: 2 <= WIDTH <= 32, 2 <= MOD <= 2**WIDTH.
module t_counter_n #(
  parameter int unsigned     WIDTH = 8,
  parameter longint unsigned MOD   = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [1:0] MODE_UP  = 2'b00;
  localparam logic [1:0] MODE_DN  = 2'b01;
  localparam logic [1:0] MODE_TOG = 2'b10;
  localparam logic [1:0] MODE_LD  = 2'b11;

  // Highest legal count. When MOD == 2**WIDTH this is all ones, so the
  // "greater than MAX_C" legality test below can never fire.
  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MOD - 64'd1);
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic             ovf_r;

  logic [WIDTH-1:0] q_nxt_s;
  logic             wrap_nxt_s;
  logic             ovf_set_s;
  logic [WIDTH-1:0] tog_s;
  logic             at_max_s;
  logic             at_zero_s;

  assign tog_s     = q_r ^ din;
  assign at_max_s  = (q_r == MAX_C);
  assign at_zero_s = (q_r == ZERO_C);

  // Next-state selection: the toggle cells' combined next value, the wrap
  // request and the overflow-set condition for the current mode.
  always_comb begin
    q_nxt_s    = q_r;
    wrap_nxt_s = 1'b0;
    ovf_set_s  = 1'b0;
    if (en) begin
      case (mode)
        MODE_UP: begin
          if (at_max_s) begin
            q_nxt_s    = ZERO_C;
            wrap_nxt_s = 1'b1;
            ovf_set_s  = 1'b1;
          end else begin
            q_nxt_s = q_r + ONE_C;
          end
        end
        MODE_DN: begin
          if (at_zero_s) begin
            q_nxt_s    = MAX_C;
            wrap_nxt_s = 1'b1;
            ovf_set_s  = 1'b1;
          end else begin
            q_nxt_s = q_r - ONE_C;
          end
        end
        MODE_TOG: begin
          // An out-of-range toggle result is refused: q holds, flag it.
          if (tog_s > MAX_C) begin
            ovf_set_s = 1'b1;
          end else begin
            q_nxt_s = tog_s;
          end
        end
        MODE_LD: begin
          // An out-of-range load value is refused: q holds, flag it.
          if (din > MAX_C) begin
            ovf_set_s = 1'b1;
          end else begin
            q_nxt_s = din;
          end
        end
        default: begin
          q_nxt_s    = q_r;
          wrap_nxt_s = 1'b0;
          ovf_set_s  = 1'b0;
        end
      endcase
    end else begin
      q_nxt_s    = q_r;
      wrap_nxt_s = 1'b0;
      ovf_set_s  = 1'b0;
    end
  end

  // State registers: count, one-cycle wrap pulse, and set-dominant sticky
  // overflow whose clear acts regardless of en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r    <= ZERO_C;
      wrap_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      q_r    <= q_nxt_s;
      wrap_r <= wrap_nxt_s;
      ovf_r  <= ovf_set_s | (ovf_r & ~clr_ovf);
    end
  end

  assign q    = q_r;
  assign wrap = wrap_r;
  assign ovf  = ovf_r;

  // Terminal-count lookahead is deliberately unregistered so that a chained
  // stage sees its enable in the same cycle the low stage is about to wrap.
  assign tc = en & (((mode == MODE_UP) & at_max_s) |
                    ((mode == MODE_DN) & at_zero_s));

endmodule

// File: tb/tb_t_counter_n.sv
// Scoreboard bench for t_counter_n (WIDTH=4, MOD=10) plus a two-stage
// decimal cascade. The driver pushes hand-computed expectations; a monitor
// pops one per clock edge (or per asynchronous reset) and compares.
module tb_t_counter_n;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] din;
  logic       clr_ovf;
  logic [3:0] q;
  logic       tc;
  logic       wrap;
  logic       ovf;

  logic       cen;
  logic [3:0] lo_q;
  logic       lo_tc;
  logic       lo_wrap;
  logic       lo_ovf;
  logic [3:0] hi_q;
  logic       hi_tc;
  logic       hi_wrap;
  logic       hi_ovf;

  typedef struct {
    bit         casc;
    logic [3:0] q;
    logic       wrap;
    logic       ovf;
    logic       tc;
    logic [3:0] lo;
    logic [3:0] hi;
    logic       lo_tc;
    logic       hi_tc;
    logic       lo_wrap;
    logic       hi_wrap;
    logic       lo_ovf;
    logic       hi_ovf;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  t_counter_n #(.WIDTH(4), .MOD(10)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din),
    .clr_ovf(clr_ovf), .q(q), .tc(tc), .wrap(wrap), .ovf(ovf)
  );

  t_counter_n #(.WIDTH(4), .MOD(10)) u_lo (
    .clk(clk), .rst(rst), .en(cen), .mode(2'b00), .din(4'b0000),
    .clr_ovf(1'b0), .q(lo_q), .tc(lo_tc), .wrap(lo_wrap), .ovf(lo_ovf)
  );

  t_counter_n #(.WIDTH(4), .MOD(10)) u_hi (
    .clk(clk), .rst(rst), .en(lo_tc), .mode(2'b00), .din(4'b0000),
    .clr_ovf(1'b0), .q(hi_q), .tc(hi_tc), .wrap(hi_wrap), .ovf(hi_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Monitor: outputs settle 1 time unit after a clock edge or reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.casc) begin
          chk4({e.name, ".lo"}, lo_q, e.lo);
          chk4({e.name, ".hi"}, hi_q, e.hi);
          chk1({e.name, ".lo_tc"}, lo_tc, e.lo_tc);
          chk1({e.name, ".hi_tc"}, hi_tc, e.hi_tc);
          chk1({e.name, ".lo_wrap"}, lo_wrap, e.lo_wrap);
          chk1({e.name, ".hi_wrap"}, hi_wrap, e.hi_wrap);
          chk1({e.name, ".lo_ovf"}, lo_ovf, e.lo_ovf);
          chk1({e.name, ".hi_ovf"}, hi_ovf, e.hi_ovf);
        end else begin
          chk4({e.name, ".q"}, q, e.q);
          chk1({e.name, ".wrap"}, wrap, e.wrap);
          chk1({e.name, ".ovf"}, ovf, e.ovf);
          chk1({e.name, ".tc"}, tc, e.tc);
        end
      end
    end
  end

  task automatic push_main(input logic [3:0] eq, input logic ew, input logic eo,
                           input logic et, input string nm);
    exp_t e;
    e = '{casc: 1'b0, q: eq, wrap: ew, ovf: eo, tc: et,
          lo: 4'd0, hi: 4'd0, lo_tc: 1'b0, hi_tc: 1'b0,
          lo_wrap: 1'b0, hi_wrap: 1'b0, lo_ovf: 1'b0, hi_ovf: 1'b0, name: nm};
    sb.push_back(e);
  endtask

  // Apply one vector at the falling edge; expectation is for after the next rise.
  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [3:0] d, input logic c,
                      input logic [3:0] eq, input logic ew, input logic eo,
                      input logic et, input string nm);
    @(negedge clk);
    rst     = r;
    en      = e;
    mode    = m;
    din     = d;
    clr_ovf = c;
    push_main(eq, ew, eo, et, nm);
  endtask

  initial begin
    exp_t ce;
    rst = 1'b0; en = 1'b0; mode = 2'b00; din = 4'd0; clr_ovf = 1'b0; cen = 1'b0;

    step(1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "reset");
    step(1'b1, 1'b1, 2'b00, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, "rel_up");
    for (int i = 2; i <= 7; i++)
      step(1'b1, 1'b1, 2'b00, 4'd0, 1'b0, 4'(i), 1'b0, 1'b0, 1'b0, "up_a");
    step(1'b1, 1'b1, 2'b11, 4'd12, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0, "load_bad_mid");
    step(1'b1, 1'b1, 2'b00, 4'd0, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0, "up_8");
    step(1'b1, 1'b1, 2'b00, 4'd0, 1'b0, 4'd9, 1'b0, 1'b1, 1'b1, "tc_at_9");
    step(1'b1, 1'b1, 2'b00, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, "wrap_up_a");

    // Asynchronous reset during the wrap pulse, well clear of a clock edge.
    @(negedge clk);
    #2;
    mode = 2'b01;
    push_main(4'd0, 1'b0, 1'b0, 1'b1, "async_reset");
    rst = 1'b0;

    step(1'b1, 1'b1, 2'b00, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, "first_edge");
    for (int i = 2; i <= 9; i++)
      step(1'b1, 1'b1, 2'b00, 4'd0, 1'b0, 4'(i), 1'b0, 1'b0, (i == 9), "up_b");
    step(1'b1, 1'b1, 2'b00, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, "wrap_up_b");
    step(1'b1, 1'b1, 2'b00, 4'd0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, "post_wrap");
    step(1'b1, 1'b1, 2'b00, 4'd0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, "post_wrap2");
    step(1'b1, 1'b0, 2'b00, 4'd0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, "clr_en0");
    for (int i = 3; i <= 9; i++)
      step(1'b1, 1'b1, 2'b00, 4'd0, 1'b0, 4'(i), 1'b0, 1'b0, (i == 9), "up_c");
    step(1'b1, 1'b1, 2'b00, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, "clr_vs_wrap");
    step(1'b1, 1'b0, 2'b01, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, "tc_en0");
    step(1'b1, 1'b0, 2'b01, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, "clr2");
    step(1'b1, 1'b1, 2'b01, 4'd0, 1'b0, 4'd9, 1'b1, 1'b1, 1'b0, "wrap_down");
    step(1'b1, 1'b1, 2'b01, 4'd0, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0, "down_8");
    step(1'b1, 1'b1, 2'b01, 4'd0, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0, "down_7");
    step(1'b1, 1'b1, 2'b11, 4'd5, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0, "load5");
    step(1'b1, 1'b0, 2'b11, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, "clr3");
    step(1'b1, 1'b1, 2'b10, 4'b0011, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0, "toggle_ok");
    step(1'b1, 1'b1, 2'b10, 4'b1100, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0, "toggle_bad");
    step(1'b1, 1'b0, 2'b10, 4'd0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, "clr4");
    step(1'b1, 1'b1, 2'b11, 4'd9, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, "load9");
    step(1'b1, 1'b1, 2'b11, 4'd12, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0, "load_bad");
    step(1'b1, 1'b1, 2'b00, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, "switch_up_at_9");
    step(1'b1, 1'b1, 2'b01, 4'd0, 1'b0, 4'd9, 1'b1, 1'b1, 1'b0, "switch_dn_at_0");
    step(1'b1, 1'b1, 2'b00, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, "up_from_9");
    step(1'b1, 1'b1, 2'b10, 4'b1111, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, "toggle_bad_clr");
    step(1'b1, 1'b1, 2'b10, 4'b1001, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0, "toggle_to_9");
    step(1'b1, 1'b0, 2'b00, 4'd0, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0, "hold_en0");

    // Two-digit decimal cascade: 100 enabled edges return both stages to 0.
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      cen = 1'b1;
      ce.casc    = 1'b1;
      ce.q       = 4'd0;
      ce.wrap    = 1'b0;
      ce.ovf     = 1'b0;
      ce.tc      = 1'b0;
      ce.lo      = 4'(k % 10);
      ce.hi      = 4'((k / 10) % 10);
      ce.lo_tc   = ((k % 10) == 9);
      ce.hi_tc   = (k == 99);
      ce.lo_wrap = ((k % 10) == 0);
      ce.hi_wrap = (k == 100);
      ce.lo_ovf  = (k >= 10);
      ce.hi_ovf  = (k >= 100);
      ce.name    = (k == 100) ? "casc_100" : "casc";
      sb.push_back(ce);
    end
    @(negedge clk);
    cen = 1'b0;

    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d entries left expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/t_counter_n.md
# t_counter_n

Parametrised synchronous counter built from per-bit toggle cells. It generalises the single toggle flip-flop to a WIDTH-bit register with a programmable modulus and four operating modes: up, down, per-bit toggle, and load. It also provides a cascadable terminal-count lookahead, a registered wrap pulse and a sticky overflow/illegal flag. It serves as the counting and timing primitive for dividers, timers and event counters in the design.

## Interface
- WIDTH, 8, counter width in bits; legal range 2..32.
- MOD, 256, count modulus; legal values are 0..MOD-1; constraint 2 <= MOD <= 2**WIDTH.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low; 0 forces all state to reset values immediately.
- en  in  1  count enable; 0 holds all state, except that clr_ovf still acts.
- mode  in  2  operating mode; 00 up, 01 down, 10 toggle, 11 load.
- din  in  WIDTH  toggle mask in mode 10; load value in mode 11; ignored otherwise.
- clr_ovf  in  1  synchronous clear of ovf.
- q  out  WIDTH  current count.
- tc  out  1  combinational terminal-count lookahead.
- wrap  out  1  registered one-cycle pulse marking a modulus wrap.
- ovf  out  1  sticky flag; set on any wrap or illegal operation.

## Operation
- Reset (rst=0): q=0, wrap=0, ovf=0, asynchronously. tc follows its equation from q=0.
- en=0: q holds and wrap=0 on the next edge. ovf holds unless clr_ovf=1.
- Mode 00, up:
  - q<q=MOD-1: q <= q+1.
  - q=MOD-1: q <= 0, wrap <= 1, ovf <= 1.
- Mode 01, down:
  - q>0: q <= q-1.
  - q=0: q <= MOD-1, wrap <= 1, ovf <= 1.
- Mode 10, toggle: each bit i with din[i]=1 inverts; other bits hold. Let r = q XOR din.
  - r<MOD: q <= r.
  - r>=MOD: q holds, ovf <= 1, wrap <= 0.
- Mode 11, load:
  - din<MOD: q <= din.
  - din>=MOD: q holds, ovf <= 1.
  - wrap <= 0 in both cases.
- wrap is 1 only in the cycle following a wrapping edge; otherwise 0.
- tc = en & ((mode=00 & q=MOD-1) | (mode=01 & q=0)). Chaining a stage's tc to the next stage's en forms a wider counter.
- ovf: set-dominant. If a set condition and clr_ovf=1 occur on the same edge, ovf=1. clr_ovf alone gives ovf <= 0, regardless of en.
- Arithmetic is modulo MOD, never modulo 2**WIDTH. When MOD=2**WIDTH, modes 10 and 11 can never be illegal.
- Mode changes take effect on the next edge with no state carried over; switching up/down at the terminal value applies the new mode's rule.

## Timing
- Latency: q, wrap and ovf each update exactly one clk edge after sampled inputs.
- tc has zero latency: it is combinational from q, en and mode, with no register.
- Reset assertion is asynchronous. After rst returns to 1, the first rising edge performs a normal update using inputs sampled at that edge. Deassertion is synchronised externally.
- Reset mid-count: q returns to 0 at once. A wrap pulse in progress is cut and ovf clears.
- All inputs must be stable around the rising edge. There are no multicycle paths.

## Test plan
- Reset: WIDTH=4, MOD=10; drive rst=0 mid-count at q=7 -> q=0, wrap=0, ovf=0 without a clock edge. After release, en=1, mode=00 -> q=1 after the first edge.
- Up wrap: MOD=10, en=1, mode=00 from q=0 for 12 edges -> q runs 1..9, 0, 1, 2. tc=1 only while q=9. wrap=1 only in the cycle after q goes 9->0. ovf=1 from then on.
- Down wrap and tc: mode=01 from q=0 -> q=9, wrap pulse, ovf=1. tc=1 at q=0 with en=1 and 0 at q=0 with en=0. Then q counts 9, 8, 7.
- Toggle and load legality, MOD=10:
  - q=5, mode=10, din=4'b0011 -> q=6.
  - q=6, din=4'b1100 -> r=10, illegal, so q stays 6 and ovf=1.
  - mode=11, din=9 -> q=9.
  - din=12 -> q stays 9 and ovf=1.
- ovf priority: clr_ovf=1 with en=0 -> ovf=0. clr_ovf=1 on the same edge as the 9->0 wrap -> ovf=1.
- Cascade: two instances WIDTH=4, MOD=10, with the low stage's tc driving the high stage's en, both in mode=00 -> after 100 edges the low and high stages read 0, 0. The high stage increments exactly once per low-stage wrap.
